// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between the ALU result and a one-cycle-ack memory port.
// Checks alignment, formats byte enables and store data, extracts load data, and times out stalled accesses.
module load_store_unit #(
    parameter int unsigned MAX_WAIT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        rsp_wen,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic        err
);
    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    function automatic logic is_ld(input logic [5:0] op);
        return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    endfunction

    function automatic logic is_st(input logic [5:0] op);
        return op inside {ALU_SB, ALU_SH, ALU_SW};
    endfunction

    function automatic logic is_byte(input logic [5:0] op);
        return op inside {ALU_LB, ALU_LBU, ALU_SB};
    endfunction

    function automatic logic is_half(input logic [5:0] op);
        return op inside {ALU_LH, ALU_LHU, ALU_SH};
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
        return is_half(op) ? a[0] : (op inside {ALU_LW, ALU_SW}) ? |a : 1'b0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (req_valid && (is_ld(alucode) || is_st(alucode))) begin
                op_d    = alucode;
                addr_d  = addr;
                wdata_d = wdata;
                rd_d    = rd_in;
                rdata_d = '0;
                cnt_d   = '0;
                err_d   = misaligned(alucode, addr[1:0]);
                state_d = err_d ? RESP : MEM;
            end
            MEM: if (mem_ack) begin
                rdata_d = mem_rdata;
                state_d = RESP;
            end else if (cnt_q == 16'(MAX_WAIT - 1)) begin
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [31:0] shifted, ld_val;
    logic [15:0] half;
    logic        ok;

    // Load data: pick the addressed lane, then extend by opcode.
    always_comb begin
        shifted = rdata_q >> {addr_q[1:0], 3'b000};
        half    = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        ld_val  = (op_q == ALU_LB)  ? {{24{shifted[7]}}, shifted[7:0]} :
                  (op_q == ALU_LBU) ? {24'd0, shifted[7:0]} :
                  (op_q == ALU_LH)  ? {{16{half[15]}}, half} :
                  (op_q == ALU_LHU) ? {16'd0, half} : rdata_q;
    end

    always_comb begin
        req_ready = state_q == IDLE;
        mem_req   = state_q == MEM;
        mem_we    = mem_req && is_st(op_q);
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_be    = is_byte(op_q) ? 4'b0001 << addr_q[1:0] :
                    is_half(op_q) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        mem_wdata = is_byte(op_q) ? {4{wdata_q[7:0]}} :
                    is_half(op_q) ? {2{wdata_q[15:0]}} : wdata_q;
        done      = state_q == RESP;
        ok        = done && !err_q;
        err       = done && err_q;
        rsp_rd    = done ? rd_q : 5'd0;
        rsp_wen   = ok && is_ld(op_q) && |rd_q;
        rsp_data  = (ok && is_ld(op_q)) ? ld_val : 32'd0;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 256, memory-ack wait cycles before timeout (range 1..65535).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  request offered.
REQ-005 SHALL have port: req_ready  output  1  unit can accept; transfer when req_valid&&req_ready.
REQ-006 SHALL have port: alucode  input  6  operation, shared ALU code definitions (ALU_LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-007 SHALL have port: addr  input  32  effective address (ALU op1+op2 result).
REQ-008 SHALL have port: wdata  input  32  store data (rs2).
REQ-009 SHALL have port: rd_in  input  5  load destination register.
REQ-010 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out 32 (word address, [1:0]=0), mem_be out 4, mem_wdata out 32.
REQ-011 SHALL have ports: mem_ack in 1 (one-cycle completion), mem_rdata in 32 (valid with mem_ack).
REQ-012 SHALL have ports: done out 1 (one-cycle pulse), rsp_wen out 1, rsp_rd out 5, rsp_data out 32, err out 1 (pulse, with done).

Function
REQ-013 SHALL implement FSM states IDLE, MEM, RESP; req_ready=1 only in IDLE.
REQ-014 SHALL on accept of a load/store code latch alucode, addr, wdata, rd_in; go to MEM if aligned, else RESP with error.
REQ-015 SHALL accept non-load/store alucode and drop it: stay IDLE, no mem_req, no done.
REQ-016 SHALL treat misaligned as LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0; no memory access issued.
REQ-017 SHALL hold mem_req=1 and all mem_* outputs stable for every cycle in MEM; mem_req=0 elsewhere.
REQ-018 SHALL drive mem_addr={addr[31:2],2'b00}; mem_we=1 for stores only.
REQ-019 SHALL drive mem_be: byte ops 4'b0001<<addr[1:0]; half ops addr[1]?4'b1100:4'b0011; word 4'b1111 (loads and stores).
REQ-020 SHALL drive mem_wdata: SB byte replicated x4, SH halfword replicated x2, SW unchanged.
REQ-021 SHALL on mem_ack in MEM capture mem_rdata and go to RESP; mem_ack outside MEM SHALL be ignored.
REQ-022 SHALL count MEM cycles; if MAX_WAIT cycles pass with no ack, go to RESP with error, drop mem_req.
REQ-023 SHALL in RESP assert done for exactly one cycle, then return to IDLE.
REQ-024 SHALL set rsp_wen=1 only for successful loads with rd!=0; rsp_rd=latched rd.
REQ-025 SHALL form rsp_data: select byte addr[1:0] / half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; 0 for stores and errors.
REQ-026 SHALL set err=1 with done on misalignment or timeout; rsp_wen=0 then.
REQ-027 SHALL give latency: accept cycle N, mem_req from N+1, ack at cycle M, done at M+1; misaligned done at N+1.
REQ-028 SHALL hold rsp_* and err at 0 whenever done=0.

Reset
REQ-029 SHALL on rst_n=0 immediately force IDLE, timeout counter 0, mem_req=0, done=0, err=0, rsp_wen=0, rsp_data=0, rsp_rd=0, req_ready=1 after release.
REQ-030 SHALL on reset during MEM abandon the access with no done pulse; the memory side discards it.

Verification
REQ-031 SHALL cover LB addr=0x103, mem_rdata=0x80FF_FF00, ack after 3 cycles -> mem_be=4'b1000, done 1 cycle after ack, rsp_data=0xFFFF_FF80, rsp_wen=1.
REQ-032 SHALL cover SH addr=0x202, wdata=0x1234_ABCD -> mem_addr=0x200, mem_be=4'b1100, mem_wdata=0xABCD_ABCD, mem_we=1, done with rsp_wen=0.
REQ-033 SHALL cover LW addr=0x006 -> no mem_req, done+err at N+1, rsp_data=0.
REQ-034 SHALL cover LHU addr=0x010, no ack, MAX_WAIT=4 -> mem_req for 4 cycles, then done+err, req_ready=1 next cycle.
REQ-035 SHALL cover rst_n low mid-MEM, then ack -> mem_req drops at once, no done; next LW accepted normally.
REQ-036 SHALL cover back-to-back requests with req_valid held high -> second accepted only the cycle after done; ALU_ADD request dropped silently.
